// File: rtl/mux_arb_pkg.sv
// Shared types and the wrap-around priority search for round-robin arbiters.
// Used by rr_pick_comb, and through it by mux_arbiter.
package mux_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } arb_state_e;

   // Widest requester set the shared search supports (16 requesters).
   localparam int RR_MAX_BITS = 4;
   localparam int RR_MAX_N    = 2 ** RR_MAX_BITS;

   typedef struct packed {
      logic                   valid;
      logic [RR_MAX_BITS-1:0] idx;
   } rr_pick_t;

   // First set bit of req at or above ptr, wrapping; mask is N-1 for a power-of-two N.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0]    req,
                                        input logic [RR_MAX_BITS-1:0] ptr,
                                        input logic [RR_MAX_BITS-1:0] mask);
      rr_pick_t               res;
      logic [RR_MAX_BITS-1:0] cand;
      res = '0;
      // Scanning from the far end down, the last hit kept is the one nearest ptr.
      for (int i = RR_MAX_N - 1; i >= 0; i--) begin
         cand = (ptr + RR_MAX_BITS'(i)) & mask;
         if (req[cand]) begin
            res.valid = 1'b1;
            res.idx   = cand;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational round-robin winner search over 2**SEL_BITS requesters (SEL_BITS <= 4).
// Wraps the package rr_pick function so other shared-resource arbiters can reuse it.
module rr_pick_comb
   import mux_arb_pkg::*;
#(
   parameter int SEL_BITS = 2
) (
   input  logic [2**SEL_BITS-1:0] req,
   input  logic [SEL_BITS-1:0]    ptr,
   output logic                   valid,
   output logic [SEL_BITS-1:0]    idx
);

   localparam int N = 2 ** SEL_BITS;

   logic [RR_MAX_N-1:0]    req_ext;
   logic [RR_MAX_BITS-1:0] ptr_ext;
   rr_pick_t               pick;
   logic                   unused_idx_bits;

   always_comb begin
      req_ext          = '0;
      req_ext[N-1:0]   = req;
      ptr_ext          = '0;
      ptr_ext[SEL_BITS-1:0] = ptr;
      pick             = rr_pick(req_ext, ptr_ext, RR_MAX_BITS'(N - 1));
   end

   assign valid           = pick.valid;
   assign idx             = pick.idx[SEL_BITS-1:0];
   assign unused_idx_bits = ^pick.idx;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter/sequencer for a shared mux + capture register datapath.
// Optional grant timeout enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_arbiter
   import mux_arb_pkg::*;
#(
   parameter int switch_bits = 2,
   parameter int max_hold    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [2**switch_bits-1:0] req,
   input  logic                      rel,
   output logic [switch_bits-1:0]    sel,
   output logic [2**switch_bits-1:0] gnt,
   output logic                      busy,
   output logic                      reg_en,
   output logic                      tmo
);

   arb_state_e             state_q, state_d;
   logic [switch_bits-1:0] sel_q, sel_d;
   logic [switch_bits-1:0] ptr_q, ptr_d;
   logic                   pick_valid;
   logic [switch_bits-1:0] pick_idx;
   logic                   own_req;
   logic                   hold_expired;

   rr_pick_comb #(
      .SEL_BITS(switch_bits)
   ) u_pick (
      .req  (req),
      .ptr  (ptr_q),
      .valid(pick_valid),
      .idx  (pick_idx)
   );

   assign own_req = req[sel_q];

`ifdef MUX_ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(max_hold - 1);

   logic [7:0] hold_q, hold_d;
   logic       tmo_q, tmo_d;

   assign hold_expired = (hold_q == HOLD_LAST);

   // Counter is zero in every non-OWN state, so entering OWN starts it from zero.
   always_comb begin
      hold_d = '0;
      tmo_d  = 1'b0;
      if (state_q == OWN) begin
         hold_d = hold_q + 8'd1;
         tmo_d  = hold_expired & own_req & ~rel;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hold_q <= '0;
         tmo_q  <= 1'b0;
      end else begin
         hold_q <= hold_d;
         tmo_q  <= tmo_d;
      end
   end

   assign tmo = tmo_q;
`else
   localparam int unused_max_hold = max_hold;

   assign hold_expired = 1'b0;
   assign tmo          = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               sel_d   = pick_idx;
               state_d = OWN;
            end
         end
         OWN: begin
            // Release, request drop and timeout all end the grant the same way.
            if (rel || !own_req || hold_expired) begin
               ptr_d   = sel_q + switch_bits'(1);
               state_d = GAP;
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      gnt = '0;
      if (state_q == OWN) gnt[sel_q] = 1'b1;
   end

   assign sel    = sel_q;
   assign busy   = (state_q != IDLE);
   assign reg_en = (state_q == OWN) & own_req & ~rel;

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter; define MUX_ARB_TIMEOUT_EN to cover the timeout build.
// Inputs change on negedge, outputs are checked 1ns after posedge against a behavioural model.
module tb_mux_arbiter;

   localparam int SB = 2;
   localparam int N  = 4;
`ifdef MUX_ARB_TIMEOUT_EN
   localparam int MAX_HOLD = 4;
   localparam bit TMO_EN   = 1'b1;
`else
   localparam int MAX_HOLD = 16;
   localparam bit TMO_EN   = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          rel;
   logic [N-1:0]  req;
   logic [SB-1:0] sel;
   logic [N-1:0]  gnt;
   logic          busy;
   logic          reg_en;
   logic          tmo;

   int checks = 0;
   int errors = 0;

   logic [SB-1:0] exp_q[$];

   // Reference model: who owns the datapath, whether a settle cycle is pending, next priority.
   int m_owner = -1;
   bit m_gap   = 1'b0;
   int m_ptr   = 0;
   int m_sel   = 0;
   bit m_tmo   = 1'b0;
   int m_len   = 0;

   always #5 clk = ~clk;

   mux_arbiter #(
      .switch_bits(SB),
      .max_hold   (MAX_HOLD)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .rel   (rel),
      .sel   (sel),
      .gnt   (gnt),
      .busy  (busy),
      .reg_en(reg_en),
      .tmo   (tmo)
   );

   function automatic logic [N-1:0] m_gnt();
      logic [N-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   function automatic logic m_busy();
      return (m_owner >= 0) || m_gap;
   endfunction

   function automatic logic m_reg_en();
      return (m_owner >= 0) && req[m_owner] && !rel;
   endfunction

   function automatic void model_edge(input logic [N-1:0] r, input logic l, input logic rs);
      bit done;
      bit found;
      if (!rs) begin
         m_owner = -1; m_gap = 1'b0; m_ptr = 0; m_sel = 0; m_tmo = 1'b0; m_len = 0;
      end else if (m_owner >= 0) begin
         m_len = m_len + 1;
         m_tmo = 1'b0;
         done  = 1'b0;
         if (l || !r[m_owner]) done = 1'b1;
         else if (TMO_EN && m_len == MAX_HOLD) begin
            done  = 1'b1;
            m_tmo = 1'b1;
         end
         if (done) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_gap   = 1'b1;
         end
      end else if (m_gap) begin
         m_gap = 1'b0;
         m_tmo = 1'b0;
      end else begin
         m_tmo = 1'b0;
         found = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!found && r[(m_ptr + i) % N]) begin
               found   = 1'b1;
               m_owner = (m_ptr + i) % N;
            end
         end
         if (found) begin
            m_sel = m_owner;
            m_len = 0;
         end
      end
   endfunction

   task automatic tick(input logic [N-1:0] r, input logic l, input logic rs);
      @(negedge clk);
      req = r;
      rel = l;
      rst = rs;
      @(posedge clk);
      model_edge(r, l, rs);
      #1;
   endtask

   task automatic test_reset();
      tick(4'b1111, 1'b0, 1'b0);
      tick(4'b1111, 1'b0, 1'b0);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (reg_en !== 1'b0) begin errors++; $display("FAIL reset_reg_en: got %b want 0", reg_en); end
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL reset_tmo: got %b want 0", tmo); end
      tick(4'b1111, 1'b0, 1'b1);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b want 0001", gnt); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_first_busy: got %b want 1", busy); end
   endtask

   task automatic test_rotation();
      int           own_cnt = 0;
      int           idle_cnt = 0;
      int           seen = 0;
      bit           first = 1'b1;
      logic         r;
      logic [N-1:0] prev;
      logic [N-1:0] exp_oh;
      logic [SB-1:0] exp_idx;
      exp_q.delete();
      exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
      exp_q.push_back(2'd3); exp_q.push_back(2'd0);
      tick(4'b1111, 1'b0, 1'b0);
      prev = gnt;
      for (int c = 0; c < 80 && seen < 5; c++) begin
         r = (gnt != '0) && (own_cnt == 3);
         tick(4'b1111, r, 1'b1);
         if (gnt != '0 && prev == '0) begin
            exp_idx = exp_q.pop_front();
            exp_oh  = '0;
            exp_oh[exp_idx] = 1'b1;
            checks++; if (gnt !== exp_oh) begin errors++; $display("FAIL rotation_order: got %b want %b", gnt, exp_oh); end
            if (!first) begin
               checks++; if (idle_cnt != 2) begin errors++; $display("FAIL rotation_gap: got %0d idle cycles want 2", idle_cnt); end
            end
            first = 1'b0; own_cnt = 1; idle_cnt = 0; seen++;
         end else if (gnt != '0) own_cnt++;
         else idle_cnt++;
         checks++; if (gnt !== m_gnt()) begin errors++; $display("FAIL rotation_model: got %b want %b", gnt, m_gnt()); end
         prev = gnt;
      end
      checks++; if (seen != 5) begin errors++; $display("FAIL rotation_timeout: got %0d grants want 5", seen); end
   endtask

   task automatic test_wrap_priority();
      tick(4'b0100, 1'b0, 1'b0);
      tick(4'b0100, 1'b0, 1'b1);
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_owner2: got %b want 0100", gnt); end
      tick(4'b0100, 1'b1, 1'b1);
      checks++; if (gnt !== 4'b0000 || busy !== 1'b1 || sel !== 2'd2) begin
         errors++; $display("FAIL wrap_gap: got gnt=%b busy=%b sel=%0d want 0000/1/2", gnt, busy, sel);
      end
      tick(4'b0011, 1'b0, 1'b1);
      checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin
         errors++; $display("FAIL wrap_idle: got gnt=%b busy=%b want 0000/0", gnt, busy);
      end
      tick(4'b0011, 1'b0, 1'b1);
      checks++; if (gnt !== 4'b0001 || sel !== 2'd0) begin
         errors++; $display("FAIL wrap_winner: got gnt=%b sel=%0d want 0001/0", gnt, sel);
      end
   endtask

   task automatic test_abort();
      tick(4'b0010, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         tick(4'b0010, 1'b0, 1'b1);
         checks++; if (reg_en !== 1'b1 || gnt !== 4'b0010) begin
            errors++; $display("FAIL abort_hold_%0d: got reg_en=%b gnt=%b want 1/0010", c, reg_en, gnt);
         end
      end
      tick(4'b0000, 1'b0, 1'b1);
      checks++; if (gnt !== 4'b0000 || busy !== 1'b1 || sel !== 2'd1) begin
         errors++; $display("FAIL abort_gap: got gnt=%b busy=%b sel=%0d want 0000/1/1", gnt, busy, sel);
      end
      req = 4'b0010;
      #1;
      checks++; if (reg_en !== 1'b0) begin errors++; $display("FAIL abort_gap_reg_en: got %b want 0", reg_en); end
   endtask

   task automatic test_reset_mid_own();
      tick(4'b0010, 1'b0, 1'b0);
      tick(4'b0010, 1'b0, 1'b1);
      tick(4'b0010, 1'b1, 1'b1);
      tick(4'b1000, 1'b0, 1'b1);
      tick(4'b1000, 1'b0, 1'b1);
      checks++; if (sel !== 2'd3 || gnt !== 4'b1000) begin
         errors++; $display("FAIL midown_setup: got sel=%0d gnt=%b want 3/1000", sel, gnt);
      end
      tick(4'b1000, 1'b0, 1'b0);
      checks++; if (gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL midown_reset: got gnt=%b sel=%0d busy=%b want 0000/0/0", gnt, sel, busy);
      end
      tick(4'b1010, 1'b0, 1'b1);
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL midown_ptr: got %b want 0010", gnt); end
   endtask

`ifdef MUX_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int hi = 0;
      logic [N-1:0] g_hist[12];
      logic         t_hist[12];
      tick(4'b0110, 1'b0, 1'b0);
      for (int c = 0; c < 12; c++) begin
         tick(4'b0110, 1'b0, 1'b1);
         g_hist[c] = gnt;
         t_hist[c] = tmo;
         if (c < 6 && gnt == 4'b0010) hi++;
         checks++; if (tmo !== m_tmo || gnt !== m_gnt()) begin
            errors++; $display("FAIL timeout_model_%0d: got tmo=%b gnt=%b want %b/%b", c, tmo, gnt, m_tmo, m_gnt());
         end
      end
      checks++; if (hi != 4) begin errors++; $display("FAIL timeout_len: got %0d want 4", hi); end
      checks++; if (t_hist[4] !== 1'b1 || t_hist[3] !== 1'b0 || t_hist[5] !== 1'b0) begin
         errors++; $display("FAIL timeout_pulse: got %b%b%b want 010", t_hist[3], t_hist[4], t_hist[5]);
      end
      checks++; if (g_hist[6] !== 4'b0100) begin errors++; $display("FAIL timeout_next: got %b want 0100", g_hist[6]); end
   endtask
`else
   task automatic test_no_timeout();
      int hi = 0;
      int pulses = 0;
      tick(4'b0010, 1'b0, 1'b0);
      for (int c = 0; c < 40; c++) begin
         tick(4'b0010, 1'b0, 1'b1);
         if (gnt == 4'b0010) hi++;
         if (tmo) pulses++;
      end
      checks++; if (hi != 40) begin errors++; $display("FAIL unbounded_grant: got %0d want 40", hi); end
      checks++; if (pulses != 0) begin errors++; $display("FAIL tmo_tied: got %0d pulses want 0", pulses); end
   endtask
`endif

   task automatic test_random();
      logic [N-1:0] r;
      logic         l;
      logic         rs;
      tick(4'b0000, 1'b0, 1'b0);
      for (int c = 0; c < 400; c++) begin
         r  = N'($urandom_range(0, 2**N - 1));
         l  = ($urandom_range(0, 3) == 0);
         rs = ($urandom_range(0, 49) != 0);
         tick(r, l, rs);
         checks++; if (gnt !== m_gnt()) begin errors++; $display("FAIL rand_gnt c%0d: got %b want %b", c, gnt, m_gnt()); end
         checks++; if (sel !== SB'(m_sel)) begin errors++; $display("FAIL rand_sel c%0d: got %0d want %0d", c, sel, m_sel); end
         checks++; if (busy !== m_busy()) begin errors++; $display("FAIL rand_busy c%0d: got %b want %b", c, busy, m_busy()); end
         checks++; if (reg_en !== m_reg_en()) begin errors++; $display("FAIL rand_reg_en c%0d: got %b want %b", c, reg_en, m_reg_en()); end
         checks++; if (tmo !== m_tmo) begin errors++; $display("FAIL rand_tmo c%0d: got %b want %b", c, tmo, m_tmo); end
      end
   endtask

   initial begin
      rst = 1'b0;
      req = '0;
      rel = 1'b0;
      test_reset();
      test_rotation();
      test_wrap_priority();
      test_abort();
      test_reset_mid_own();
`ifdef MUX_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
